serial_operand_driver: RTL and testbench
========================================

// Module: serial_operand_driver
// PURPOSE
//  Host-side end of the size-exploration bit-serial operand interface. Accepts parallel operands
//  A/B and shifts them MSB-first onto lanes 0/1, which the DUT wrapper shifts in every clock.
//  Drives the byte-select line and reads the 32-bit result back over two 16-bit passes.
//  Sits in the FPGA test harness / testbench, sharing clk with the DUT wrapper.
// PARAMETERS
//  WIDTH     6          operand width in bits, 1..16.
//  OUT_BITS  2*WIDTH    valid result bits, 1..32; result bits >= OUT_BITS are forced to 0.
// PORTS
//  clk        in   1      clock, shared with the DUT wrapper.
//  reset      in   1      asynchronous, active-high reset.
//  op_valid   in   1      operand pair offered.
//  op_ready   out  1      high only in IDLE; transfer on op_valid & op_ready.
//  op_a       in   WIDTH  operand A.
//  op_b       in   WIDTH  operand B.
//  res_valid  out  1      result held valid until taken.
//  res_ready  in   1      result consumed on res_valid & res_ready.
//  res_data   out  32     assembled result.
//  lane_a     out  1      serial A, drives ui_in[0]; registered.
//  lane_b     out  1      serial B, drives ui_in[1]; registered.
//  lane_c     out  1      ui_in[2]; constant 0.
//  sel        out  1      drives ui_in[7]; 1 = low bytes, 0 = high bytes; registered.
//  dut_uo     in   8      from uo_out.
//  dut_uio    in   8      from uio_out.
// BEHAVIOUR
//  Reset (async): state IDLE; lane_a/b = 0, sel = 1, res_valid = 0, res_data = 0; op_ready = 1.
//  op_ready is (state == IDLE). Operands are latched on the accept edge; later op_a/op_b changes are ignored.
//  FSM: IDLE -> SHIFT1 -> CAP1 -> SHIFT2 -> CAP2 -> DONE -> IDLE.
//  - SHIFT1: WIDTH cycles, sel = 1. Cycle k (0..WIDTH-1) drives lane_a = A[WIDTH-1-k] and lane_b = B[WIDTH-1-k].
//    A down-counter tracks the bit; the last SHIFT cycle drives bit 0.
//  - CAP1: 1 cycle, sel held. The DUT register now holds exactly A/B in its low bits.
//    - At the end of CAP1: res_data[7:0] <= dut_uo; res_data[23:16] <= dut_uio.
//    - Lanes drive 0 during CAP cycles; what the DUT shifts in afterwards is don't-care.
//  - If OUT_BITS <= 8: CAP1 -> DONE, and res_data[31:8] is cleared.
//  - SHIFT2: repeat the SHIFT1 sequence with sel = 0, because the DUT register never holds.
//  - CAP2: at the end of CAP2, res_data[15:8] <= dut_uo; res_data[31:24] <= dut_uio.
//  - DONE: res_valid = 1; res_data is masked to OUT_BITS and stable.
//    On res_valid & res_ready, go to IDLE and clear res_valid. A new op can be accepted the next cycle.
//  sel changes only on the edge entering SHIFT1/SHIFT2, never during a CAP cycle.
//  Latency from the accept edge to res_valid high:
//    2*WIDTH+2 cycles (two passes); WIDTH+1 cycles (one pass).
//  Backpressure: if res_ready is low, DONE holds indefinitely with res_data frozen and op_ready = 0.
//  Reset mid-operation: immediate return to IDLE with all outputs at reset values.
//    The partial result is discarded; the DUT needs no flush, since the next full shift overwrites its low WIDTH bits.
//  op_valid during a non-IDLE state is ignored (not queued).
//  WIDTH = 1: one SHIFT cycle per pass; no counter underflow.
// TESTING
//  1. WIDTH=6, MULT DUT model, A=45, B=27 -> res_data=1215.
//     res_valid rises exactly 14 cycles after accept.
//  2. A=6'b101101 -> lane_a samples 1,0,1,1,0,1 in SHIFT1 and the same in SHIFT2.
//     sel=1 for SHIFT1 and CAP1, sel=0 for SHIFT2 and CAP2.
//  3. A=B=63 -> res_data=3969; res_data[31:12]=0.
//  4. res_ready held low 5 cycles in DONE -> res_valid and res_data stable, op_ready=0.
//     Then a back-to-back op is accepted on the cycle after the handshake.
//  5. Assert reset during SHIFT2 -> outputs at reset values asynchronously.
//     The next op A=3, B=5 -> 15.
//  6. WIDTH=4, OUT_BITS=8, A=B=15 -> single pass, res_data=225, res_valid after 5 cycles, sel never 0.

Source files
------------

// File: rtl/serial_operand_driver.sv
// serial_operand_driver
// Host-side end of the bit-serial operand interface. Operands A/B are shifted
// MSB-first onto two lanes. The 32-bit result is then read back through two
// byte-select passes, or one pass when the result fits in 8 bits.
// The DUT register is re-shifted with the same operands before the second pass
// because it does not hold its contents between passes.
module serial_operand_driver #(
    parameter int WIDTH    = 6,
    parameter int OUT_BITS = 2 * WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [31:0]      o_res_data,
    output logic             o_lane_a,
    output logic             o_lane_b,
    output logic             o_lane_c,
    output logic             o_sel,
    input  logic [7:0]       i_dut_uo,
    input  logic [7:0]       i_dut_uio
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic          ONE_PASS = (OUT_BITS <= 8);

    // Mask that keeps only result bits below the given count.
    function automatic logic [31:0] result_mask(input int bits);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    localparam logic [31:0] RES_MASK = result_mask(OUT_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT1 = 3'd1,
        S_CAP1   = 3'd2,
        S_SHIFT2 = 3'd3,
        S_CAP2   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;
    logic [CW-1:0]     w_bit_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  w_a_next;
    logic [WIDTH-1:0]  w_b_next;
    logic              r_lane_a;
    logic              r_lane_b;
    logic              w_lane_a_next;
    logic              w_lane_b_next;
    logic              r_sel;
    logic              w_sel_next;
    logic [31:0]       r_res_data;
    logic [31:0]       w_res_next;
    logic              r_res_valid;
    logic              w_valid_next;
    logic              r_op_ready;
    logic              w_ready_next;

    // The next bit to drive sits one below the current down-counter value.
    assign w_bit_idx = r_cnt - CW'(1);

    // Next-state and next-value logic for the whole transfer sequence.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_lane_a_next = 1'b0;
        w_lane_b_next = 1'b0;
        w_sel_next    = r_sel;
        w_res_next    = r_res_data;
        w_valid_next  = r_res_valid;
        case (r_state)
            S_IDLE: begin
                if (i_op_valid) begin
                    w_state_next  = S_SHIFT1;
                    w_a_next      = i_op_a;
                    w_b_next      = i_op_b;
                    w_lane_a_next = i_op_a[WIDTH-1];
                    w_lane_b_next = i_op_b[WIDTH-1];
                    w_sel_next    = 1'b1;
                    w_cnt_next    = CNT_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT1, S_SHIFT2: begin
                if (r_cnt == {CW{1'b0}}) begin
                    // Bit 0 has just been shifted; lanes fall to 0 for the capture cycle.
                    w_state_next = (r_state == S_SHIFT1) ? S_CAP1 : S_CAP2;
                end else begin
                    w_lane_a_next = r_a[w_bit_idx];
                    w_lane_b_next = r_b[w_bit_idx];
                    w_cnt_next    = w_bit_idx;
                end
            end
            S_CAP1: begin
                w_res_next[7:0]   = i_dut_uo;
                w_res_next[23:16] = i_dut_uio;
                if (ONE_PASS) begin
                    w_res_next[31:8] = 24'd0;
                    w_state_next     = S_DONE;
                    w_valid_next     = 1'b1;
                end else begin
                    // Re-shift the same operands with the high-byte select.
                    w_state_next  = S_SHIFT2;
                    w_lane_a_next = r_a[WIDTH-1];
                    w_lane_b_next = r_b[WIDTH-1];
                    w_sel_next    = 1'b0;
                    w_cnt_next    = CNT_LOAD;
                end
            end
            S_CAP2: begin
                w_res_next[15:8]  = i_dut_uo;
                w_res_next[31:24] = i_dut_uio;
                w_state_next      = S_DONE;
                w_valid_next      = 1'b1;
            end
            S_DONE: begin
                if (i_res_ready) begin
                    w_state_next = S_IDLE;
                    w_valid_next = 1'b0;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_valid_next = 1'b0;
            end
        endcase
        w_ready_next = (w_state_next == S_IDLE);
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and output registers; the result is always kept masked.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt       <= {CW{1'b0}};
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_lane_a    <= 1'b0;
            r_lane_b    <= 1'b0;
            r_sel       <= 1'b1;
            r_res_data  <= 32'd0;
            r_res_valid <= 1'b0;
            r_op_ready  <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_next;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_lane_a    <= w_lane_a_next;
            r_lane_b    <= w_lane_b_next;
            r_sel       <= w_sel_next;
            r_res_data  <= w_res_next & RES_MASK;
            r_res_valid <= w_valid_next;
            r_op_ready  <= w_ready_next;
        end
    end

    assign o_op_ready  = r_op_ready;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_lane_a    = r_lane_a;
    assign o_lane_b    = r_lane_b;
    assign o_lane_c    = 1'b0;
    assign o_sel       = r_sel;

endmodule

// File: tb/tb_serial_operand_driver.sv
// Self-checking bench for serial_operand_driver. Two instances are exercised:
// a two-pass one (WIDTH=6) and a one-pass one (WIDTH=4, OUT_BITS=8). Each
// instance is wired to a multiplier DUT model. The model also drives junk on
// result bits above OUT_BITS.
module tb_serial_operand_driver;

    localparam int          W     = 6;
    localparam int          LAT   = 2 * W + 2;
    localparam logic [31:0] MASK1 = 32'h0000_0FFF;
    localparam logic [31:0] JUNK1 = 32'hC3A5_9000;
    localparam logic [31:0] MASK2 = 32'h0000_00FF;
    localparam logic [31:0] JUNK2 = 32'hC3A5_5A00;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        rst2 = 1'b0;

    logic        op_valid, op_ready, res_valid, res_ready;
    logic [5:0]  op_a, op_b;
    logic [31:0] res_data;
    logic        lane_a, lane_b, lane_c, sel;
    logic [7:0]  dut_uo, dut_uio;

    logic        op_valid2, op_ready2, res_valid2, res_ready2;
    logic [3:0]  op_a2, op_b2;
    logic [31:0] res_data2;
    logic        lane_a2, lane_b2, lane_c2, sel2;
    logic [7:0]  dut_uo2, dut_uio2;

    int total = 0;
    int bad   = 0;
    logic done2     = 1'b0;
    logic sel2_zero = 1'b0;

    always #5 clk = ~clk;

    serial_operand_driver #(.WIDTH(6), .OUT_BITS(12)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_op_valid(op_valid), .o_op_ready(op_ready),
        .i_op_a(op_a), .i_op_b(op_b), .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_lane_a(lane_a), .o_lane_b(lane_b), .o_lane_c(lane_c),
        .o_sel(sel), .i_dut_uo(dut_uo), .i_dut_uio(dut_uio)
    );

    serial_operand_driver #(.WIDTH(4), .OUT_BITS(8)) u_dut2 (
        .i_clk(clk), .i_reset(rst2), .i_op_valid(op_valid2), .o_op_ready(op_ready2),
        .i_op_a(op_a2), .i_op_b(op_b2), .o_res_valid(res_valid2), .i_res_ready(res_ready2),
        .o_res_data(res_data2), .o_lane_a(lane_a2), .o_lane_b(lane_b2), .o_lane_c(lane_c2),
        .o_sel(sel2), .i_dut_uo(dut_uo2), .i_dut_uio(dut_uio2)
    );

    // Multiplier DUT wrapper models: shift registers fed by the lanes, no reset.
    logic [15:0] dm_a  = 16'd0, dm_b  = 16'd0;
    logic [15:0] dm2_a = 16'd0, dm2_b = 16'd0;
    logic [31:0] dm_p, dm2_p;
    always @(posedge clk) begin
        dm_a  <= {dm_a[14:0], lane_a};
        dm_b  <= {dm_b[14:0], lane_b};
        dm2_a <= {dm2_a[14:0], lane_a2};
        dm2_b <= {dm2_b[14:0], lane_b2};
    end
    assign dm_p     = ({26'd0, dm_a[5:0]} * {26'd0, dm_b[5:0]}) | JUNK1;
    assign dut_uo   = sel ? dm_p[7:0]   : dm_p[15:8];
    assign dut_uio  = sel ? dm_p[23:16] : dm_p[31:24];
    assign dm2_p    = ({28'd0, dm2_a[3:0]} * {28'd0, dm2_b[3:0]}) | JUNK2;
    assign dut_uo2  = sel2 ? dm2_p[7:0]   : dm2_p[15:8];
    assign dut_uio2 = sel2 ? dm2_p[23:16] : dm2_p[31:24];

    // Watches the one-pass instance for any use of the high-byte select.
    always @(negedge clk) begin
        if (!rst2 && sel2 !== 1'b1) sel2_zero <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Lane value expected d cycles after accept, two-pass schedule.
    function automatic logic exp_lane(input logic [5:0] x, input int d);
        if (d < W) return x[W-1-d];
        else if (d == W) return 1'b0;
        else if (d <= 2 * W) return x[2*W-d];
        else return 1'b0;
    endfunction

    // Reference model and per-cycle compare for the two-pass instance.
    logic        m_busy = 1'b0;
    int          m_d    = 0;
    logic [5:0]  m_a    = 6'd0, m_b = 6'd0;
    logic        m_sel  = 1'b1;
    logic [31:0] m_hold = 32'd0;
    logic [31:0] m_exp;
    initial begin
        forever begin
            @(negedge clk);
            m_exp = ({26'd0, m_a} * {26'd0, m_b}) & MASK1;
            check("m_lane_c", {31'd0, lane_c}, 32'd0);
            if (rst) begin
                check("m_rst_ready", {31'd0, op_ready}, 32'd1);
                check("m_rst_valid", {31'd0, res_valid}, 32'd0);
                check("m_rst_sel", {31'd0, sel}, 32'd1);
                check("m_rst_lanes", {30'd0, lane_a, lane_b}, 32'd0);
                check("m_rst_data", res_data, 32'd0);
                m_busy = 1'b0;
                m_sel  = 1'b1;
                m_hold = 32'd0;
            end else if (!m_busy) begin
                check("m_idle_ready", {31'd0, op_ready}, 32'd1);
                check("m_idle_valid", {31'd0, res_valid}, 32'd0);
                check("m_idle_lanes", {30'd0, lane_a, lane_b}, 32'd0);
                check("m_idle_sel", {31'd0, sel}, {31'd0, m_sel});
                check("m_idle_data", res_data, m_hold);
                if (op_valid) begin
                    m_busy = 1'b1;
                    m_d    = 0;
                    m_a    = op_a;
                    m_b    = op_b;
                    m_sel  = 1'b1;
                end
            end else begin
                check("m_busy_ready", {31'd0, op_ready}, 32'd0);
                check("m_lane_a", {31'd0, lane_a}, {31'd0, exp_lane(m_a, m_d)});
                check("m_lane_b", {31'd0, lane_b}, {31'd0, exp_lane(m_b, m_d)});
                check("m_sel", {31'd0, sel}, (m_d <= W) ? 32'd1 : 32'd0);
                check("m_valid", {31'd0, res_valid}, (m_d >= LAT) ? 32'd1 : 32'd0);
                if (m_d >= LAT) check("m_data", res_data, m_exp);
                if (m_d >= LAT && res_ready) begin
                    m_busy = 1'b0;
                    m_hold = m_exp;
                    m_sel  = 1'b0;
                end else if (m_d < LAT) begin
                    m_d++;
                end
            end
        end
    end

    // One full transaction on the two-pass instance, entered and left at posedge+1.
    task automatic run_op(input logic [5:0] a, input logic [5:0] b, input int hold,
                          output int lat, output logic [31:0] data, output int wait_n,
                          output logic [15:0] lane_seq, output logic [15:0] sel_seq);
        logic [31:0] d0;
        int d;
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        wait_n = 0;
        while (!op_ready && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("accept_ready", {31'd0, op_ready}, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_a = 6'($urandom);
        op_b = 6'($urandom);
        d = 0;
        lane_seq = 16'd0;
        sel_seq = 16'd0;
        while (!res_valid && d < 100) begin
            lane_seq  = {lane_seq[14:0], lane_a};
            sel_seq   = {sel_seq[14:0], sel};
            op_valid  = 1'($urandom_range(0, 1));
            op_a      = 6'($urandom);
            op_b      = 6'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            d++;
        end
        op_valid  = 1'b0;
        res_ready = 1'b0;
        check("result_valid", {31'd0, res_valid}, 32'd1);
        lat  = d;
        data = res_data;
        d0   = res_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_data", res_data, d0);
            check("hold_ready", {31'd0, op_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("release_valid", {31'd0, res_valid}, 32'd0);
    endtask

    // Directed and random stimulus for the two-pass instance.
    initial begin
        int lat, wn, n;
        logic [31:0] data;
        logic [15:0] ls, ss;
        logic [5:0] ra, rb;
        op_valid = 1'b0; op_a = 6'd0; op_b = 6'd0; res_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_ready", {31'd0, op_ready}, 32'd1);
        check("reset_valid", {31'd0, res_valid}, 32'd0);
        check("reset_sel", {31'd0, sel}, 32'd1);
        check("reset_data", res_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 45*27, latency and lane/sel pattern (45 = 6'b101101).
        run_op(6'd45, 6'd27, 0, lat, data, wn, ls, ss);
        check("t1_result", data, 32'd1215);
        check("t1_latency", 32'(lat), 32'd14);
        check("t2_lane_seq", {18'd0, ls[13:0]}, {18'd0, 14'b10110101011010});
        check("t2_sel_seq", {18'd0, ss[13:0]}, {18'd0, 14'b11111110000000});

        // Largest operands; bits above OUT_BITS must be zero.
        run_op(6'd63, 6'd63, 1, lat, data, wn, ls, ss);
        check("t3_result", data, 32'd3969);
        check("t3_upper_zero", data >> 12, 32'd0);

        // Backpressure for 5 cycles, then a back-to-back op.
        run_op(6'd17, 6'd38, 5, lat, data, wn, ls, ss);
        check("t4_result", data, 32'd646);
        run_op(6'd9, 6'd50, 0, lat, data, wn, ls, ss);
        check("t4_b2b_wait", 32'(wn), 32'd0);
        check("t4_b2b_result", data, 32'd450);

        // Reset during SHIFT2.
        op_valid = 1'b1; op_a = 6'd63; op_b = 6'd63;
        n = 0;
        while (!op_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;
        check("t5_pre_sel", {31'd0, sel}, 32'd0);
        check("t5_pre_lane", {31'd0, lane_a}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_lanes", {30'd0, lane_a, lane_b}, 32'd0);
        check("t5_rst_sel", {31'd0, sel}, 32'd1);
        check("t5_rst_valid", {31'd0, res_valid}, 32'd0);
        check("t5_rst_data", res_data, 32'd0);
        check("t5_rst_ready", {31'd0, op_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_op(6'd3, 6'd5, 0, lat, data, wn, ls, ss);
        check("t5_next_result", data, 32'd15);

        // Random operands, holds and gaps.
        for (int i = 0; i < 40; i++) begin
            ra = 6'($urandom);
            rb = 6'($urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            run_op(ra, rb, $urandom_range(0, 3), lat, data, wn, ls, ss);
            check("rand_result", data, ({26'd0, ra} * {26'd0, rb}) & MASK1);
            check("rand_latency", 32'(lat), 32'(LAT));
        end

        n = 0;
        while (!done2 && n < 2000) begin @(posedge clk); n++; end
        check("one_pass_done", {31'd0, done2}, 32'd1);
        check("one_pass_sel_never_0", {31'd0, sel2_zero}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Stimulus and checks for the one-pass instance.
    initial begin
        int n;
        logic [3:0] a, b;
        op_valid2 = 1'b0; op_a2 = 4'd0; op_b2 = 4'd0; res_ready2 = 1'b0;
        #1 rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 4'd15 : 4'($urandom);
            b = (i == 0) ? 4'd15 : 4'($urandom);
            op_valid2 = 1'b1; op_a2 = a; op_b2 = b;
            n = 0;
            while (!op_ready2 && n < 50) begin @(posedge clk); #1; n++; end
            check("p1_accept_ready", {31'd0, op_ready2}, 32'd1);
            @(posedge clk); #1;
            op_valid2 = 1'b0; op_a2 = 4'($urandom); op_b2 = 4'($urandom);
            n = 0;
            while (!res_valid2 && n < 50) begin @(posedge clk); #1; n++; end
            check("p1_latency", 32'(n), 32'd5);
            check("p1_result", res_data2, ({28'd0, a} * {28'd0, b}) & MASK2);
            if (i == 0) check("t6_result", res_data2, 32'd225);
            check("p1_lane_c", {31'd0, lane_c2}, 32'd0);
            res_ready2 = 1'b1;
            @(posedge clk); #1;
            res_ready2 = 1'b0;
            check("p1_release", {31'd0, res_valid2}, 32'd0);
        end
        done2 = 1'b1;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
